// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade player-input conditioner: joystick word
// bit map, coin-channel state encoding and counter width.
package arcade_input_pkg;

    localparam int JB_RIGHT  = 0;
    localparam int JB_LEFT   = 1;
    localparam int JB_DOWN   = 2;
    localparam int JB_UP     = 3;
    localparam int JB_FIRE   = 4;
    localparam int JB_JUMP   = 5;
    localparam int JB_START  = 6;
    localparam int JB_SELECT = 7;
    localparam int JB_COIN   = 8;
    localparam int JB_PAUSE  = 9;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        STRETCH,
        HOLD
    } coin_st_t;

endpackage

// File: rtl/arcade_coin_stretch.sv
// One coin channel: stretches a coin press to at least COIN_FRAMES frame
// strobes and keeps it asserted while the coin input stays held.
module arcade_coin_stretch
    import arcade_input_pkg::*;
#(
    parameter int COIN_FRAMES = 3
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic fs,
    input  logic coin_raw,
    output logic coin_n
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COIN_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    coin_st_t         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             coin_prev_q, coin_prev_d;
    logic             coin_n_q, coin_n_d;
    logic             coin_edge;

    assign coin_edge   = coin_raw & ~coin_prev_q;
    assign coin_prev_d = coin_raw;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the edge.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            coin_prev_q <= 1'b0;
            coin_n_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            coin_prev_q <= coin_prev_d;
            coin_n_q    <= coin_n_d;
        end
    end

    // A load on the same cycle as a strobe wins; that strobe is not counted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (coin_edge) begin
                    state_d = STRETCH;
                    cnt_d   = CNT_LOAD;
                end
            end
            STRETCH: begin
                if (fs) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!coin_raw) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        coin_n_d = (state_d == IDLE);
    end

    assign coin_n = coin_n_q;

endmodule

// File: rtl/arcade_input_ctrl.sv
// Player-input conditioner: merges or separates player joystick words into
// active-low core inputs with coin stretching, autofire and a pause latch.
module arcade_input_ctrl
    import arcade_input_pkg::*;
#(
    parameter int NPLAYERS    = 2,
    parameter int JOY_W       = 10,
    parameter int COIN_FRAMES = 3,
    parameter int AF_FRAMES   = 4
) (
    input  logic                      clk_sys,
    input  logic                      rst_n,
    input  logic                      soft_rst,
    input  logic                      vs,
    input  logic                      merge,
    input  logic [NPLAYERS-1:0]       af_en,
    input  logic [NPLAYERS*JOY_W-1:0] joy_in,
    output logic [NPLAYERS*6-1:0]     joy_n,
    output logic [NPLAYERS-1:0]       start_n,
    output logic [NPLAYERS-1:0]       coin_n,
    output logic                      pause
);

    localparam logic [CNT_W-1:0] AF_LOAD = CNT_W'(AF_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [2:0]          vs_pipe_q, vs_pipe_d;
    logic                fs;
    logic [JB_PAUSE:0]   merged;

    logic [NPLAYERS-1:0] fire_src, af_sel, coin_raw, fire_af;
    logic [NPLAYERS-1:0] af_on_q, af_on_d, af_ph_q, af_ph_d;
    logic [CNT_W-1:0]    af_cnt_q [NPLAYERS];
    logic [CNT_W-1:0]    af_cnt_d [NPLAYERS];

    logic [NPLAYERS*6-1:0] joy_n_q, joy_n_d;
    logic [NPLAYERS-1:0]   start_n_q, start_n_d;
    logic                  pause_q, pause_d;
    logic                  pause_prev_q, pause_prev_d;
    logic                  pause_edge;

    // Two synchroniser stages, then one more stage for rising-edge detection.
    always_comb vs_pipe_d = {vs_pipe_q[1:0], vs};
    assign fs = vs_pipe_q[1] & ~vs_pipe_q[2];

    always_comb begin
        merged = '0;
        for (int i = 0; i < NPLAYERS; i++) begin
            merged |= joy_in[i*JOY_W +: JB_PAUSE+1];
        end
    end

    always_comb begin
        for (int i = 0; i < NPLAYERS; i++) begin
            fire_src[i] = merge ? merged[JB_FIRE] : joy_in[i*JOY_W + JB_FIRE];
            af_sel[i]   = merge ? af_en[0] : af_en[i];
            coin_raw[i] = merge ? ((i == 0) && merged[JB_COIN])
                                : joy_in[i*JOY_W + JB_COIN];
        end
    end

    // Autofire: a held fire alternates every AF_FRAMES strobes, starting asserted.
    always_comb begin
        for (int i = 0; i < NPLAYERS; i++) begin
            af_on_d[i]  = af_on_q[i];
            af_ph_d[i]  = af_ph_q[i];
            af_cnt_d[i] = af_cnt_q[i];
            fire_af[i]  = fire_src[i];
            if (!af_sel[i] || !fire_src[i]) begin
                af_on_d[i]  = 1'b0;
                af_ph_d[i]  = 1'b0;
                af_cnt_d[i] = '0;
            end else if (!af_on_q[i]) begin
                af_on_d[i]  = 1'b1;
                af_ph_d[i]  = 1'b1;
                af_cnt_d[i] = AF_LOAD;
            end else begin
                if (fs) begin
                    if (af_cnt_q[i] == CNT_ONE) begin
                        af_ph_d[i]  = ~af_ph_q[i];
                        af_cnt_d[i] = AF_LOAD;
                    end else begin
                        af_cnt_d[i] = af_cnt_q[i] - CNT_ONE;
                    end
                end
                fire_af[i] = af_ph_d[i];
            end
        end
    end

    assign pause_edge   = merged[JB_PAUSE] & ~pause_prev_q;
    assign pause_prev_d = merged[JB_PAUSE];

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        joy_n_d   = '1;
        start_n_d = '1;
        for (int i = 0; i < NPLAYERS; i++) begin
            if (merge) begin
                joy_n_d[i*6 +: 6] = ~{merged[JB_JUMP], fire_af[0],
                                      merged[JB_UP], merged[JB_DOWN],
                                      merged[JB_LEFT], merged[JB_RIGHT]};
                start_n_d[i] = (i == 0) ? ~merged[JB_START]  :
                               (i == 1) ? ~merged[JB_SELECT] : 1'b1;
            end else begin
                joy_n_d[i*6 +: 6] = ~{joy_in[i*JOY_W + JB_JUMP], fire_af[i],
                                      joy_in[i*JOY_W + JB_UP],
                                      joy_in[i*JOY_W + JB_DOWN],
                                      joy_in[i*JOY_W + JB_LEFT],
                                      joy_in[i*JOY_W + JB_RIGHT]};
                start_n_d[i] = ~joy_in[i*JOY_W + JB_START];
            end
        end
        pause_d = soft_rst ? 1'b0 : (pause_q ^ pause_edge);
    end

    // NOTE: the autofire counter array is a handful of flops, not a RAM, so
    // it is reset element by element along with everything else.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            vs_pipe_q    <= '0;
            af_on_q      <= '0;
            af_ph_q      <= '0;
            for (int i = 0; i < NPLAYERS; i++) begin
                af_cnt_q[i] <= '0;
            end
            joy_n_q      <= '1;
            start_n_q    <= '1;
            pause_q      <= 1'b0;
            pause_prev_q <= 1'b0;
        end else begin
            vs_pipe_q    <= vs_pipe_d;
            af_on_q      <= af_on_d;
            af_ph_q      <= af_ph_d;
            for (int i = 0; i < NPLAYERS; i++) begin
                af_cnt_q[i] <= af_cnt_d[i];
            end
            joy_n_q      <= joy_n_d;
            start_n_q    <= start_n_d;
            pause_q      <= pause_d;
            pause_prev_q <= pause_prev_d;
        end
    end

    for (genvar g = 0; g < NPLAYERS; g++) begin : g_coin
        arcade_coin_stretch #(
            .COIN_FRAMES(COIN_FRAMES)
        ) u_coin (
            .clk_sys (clk_sys),
            .rst_n   (rst_n),
            .fs      (fs),
            .coin_raw(coin_raw[g]),
            .coin_n  (coin_n[g])
        );
    end

    assign joy_n   = joy_n_q;
    assign start_n = start_n_q;
    assign pause   = pause_q;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Bench for arcade_input_ctrl: directed scenarios plus random stimulus, all
// compared cycle by cycle against a frame-counting behavioural model.
module tb_arcade_input_ctrl;

    localparam int NP = 2;
    localparam int JW = 10;
    localparam int CF = 3;
    localparam int AF = 4;

    logic              clk_sys = 1'b0;
    logic              rst_n;
    logic              soft_rst;
    logic              vs;
    logic              merge;
    logic [NP-1:0]     af_en;
    logic [NP*JW-1:0]  joy_in;
    logic [NP*6-1:0]   joy_n;
    logic [NP-1:0]     start_n;
    logic [NP-1:0]     coin_n;
    logic              pause;

    arcade_input_ctrl #(
        .NPLAYERS   (NP),
        .JOY_W      (JW),
        .COIN_FRAMES(CF),
        .AF_FRAMES  (AF)
    ) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .soft_rst(soft_rst),
        .vs      (vs),
        .merge   (merge),
        .af_en   (af_en),
        .joy_in  (joy_in),
        .joy_n   (joy_n),
        .start_n (start_n),
        .coin_n  (coin_n),
        .pause   (pause)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit vs_rand  = 1'b0;

    // Model state: vs sample history, frame counters per coin / autofire unit.
    bit hist [3];
    bit m_fs;
    bit m_pause, m_p9_prev;
    bit c_prev [NP];
    bit c_active [NP];
    int c_left [NP];
    bit a_burst [NP];
    int a_nfs [NP];

    logic [NP*6-1:0] e_joy_n;
    logic [NP-1:0]   e_start_n, e_coin_n;
    logic            e_pause;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) hist[i] = 1'b0;
        m_pause = 1'b0;
        m_p9_prev = 1'b0;
        for (int i = 0; i < NP; i++) begin
            c_prev[i] = 1'b0; c_active[i] = 1'b0; c_left[i] = 0;
            a_burst[i] = 1'b0; a_nfs[i] = 0;
        end
        e_joy_n = '1; e_start_n = '1; e_coin_n = '1; e_pause = 1'b0;
    endtask

    // Evaluate one clock edge using the inputs currently applied.
    task automatic model_step();
        logic [JW-1:0] w [NP];
        logic [JW-1:0] m, src;
        bit fire_o [NP];
        bit raw, f, e;
        m_fs = hist[1] && !hist[2];
        hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = vs;
        m = '0;
        for (int p = 0; p < NP; p++) begin
            w[p] = joy_in[p*JW +: JW];
            m |= w[p];
        end
        if (soft_rst) m_pause = 1'b0;
        else if (m[9] && !m_p9_prev) m_pause = !m_pause;
        m_p9_prev = m[9];
        for (int c = 0; c < NP; c++) begin
            raw = merge ? (c == 0 && m[8]) : w[c][8];
            if (!c_active[c]) begin
                if (raw && !c_prev[c]) begin c_active[c] = 1'b1; c_left[c] = CF; end
            end else if (c_left[c] > 0) begin
                if (m_fs) c_left[c]--;
            end else if (!raw) begin
                c_active[c] = 1'b0;
            end
            c_prev[c] = raw;
            e_coin_n[c] = !c_active[c];
        end
        for (int u = 0; u < NP; u++) begin
            f = merge ? m[4] : w[u][4];
            e = merge ? af_en[0] : af_en[u];
            if (!e || !f) begin
                a_burst[u] = 1'b0; fire_o[u] = f;
            end else if (!a_burst[u]) begin
                a_burst[u] = 1'b1; a_nfs[u] = 0; fire_o[u] = 1'b1;
            end else begin
                if (m_fs) a_nfs[u]++;
                fire_o[u] = ((a_nfs[u] / AF) % 2) == 0;
            end
        end
        for (int i = 0; i < NP; i++) begin
            src = merge ? m : w[i];
            e_joy_n[i*6 +: 6] = ~{src[5], fire_o[merge ? 0 : i], src[3:0]};
            if (merge) e_start_n[i] = (i == 0) ? !m[6] : (i == 1) ? !m[7] : 1'b1;
            else       e_start_n[i] = !w[i][6];
        end
        e_pause = m_pause;
    endtask

    task automatic check_all();
        check("joy_n",   32'(joy_n),   32'(e_joy_n));
        check("start_n", 32'(start_n), 32'(e_start_n));
        check("coin_n",  32'(coin_n),  32'(e_coin_n));
        check("pause",   32'(pause),   32'(e_pause));
    endtask

    // Drive vs, step the model, clock, then compare 1 ns after the edge.
    task automatic cycle();
        if (vs_rand) vs = ($urandom_range(0, 2) == 0);
        else         vs = ((cyc % 12) >= 8);
        cyc++;
        model_step();
        @(posedge clk_sys);
        #1;
        check_all();
    endtask

    task automatic set_word(input int p, input logic [JW-1:0] w);
        joy_in[p*JW +: JW] = w;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_joy_n"},   32'(joy_n),   32'(12'hFFF));
        check({tag, "_start_n"}, 32'(start_n), 32'(2'b11));
        check({tag, "_coin_n"},  32'(coin_n),  32'(2'b11));
        check({tag, "_pause"},   32'(pause),   32'(1'b0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fs_cnt, n;
        rst_n = 1'b0; soft_rst = 1'b0; vs = 1'b0; merge = 1'b0;
        af_en = '0; joy_in = '0;
        model_reset();
        repeat (2) @(posedge clk_sys);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;

        // Merged directions from two players
        merge = 1'b1;
        set_word(0, 10'h001);
        set_word(1, 10'h008);
        cycle();
        check("merge_dirs", 32'(joy_n), 32'(12'b110110_110110));
        joy_in = '0;
        repeat (3) cycle();

        // Coin tap: low until the 3rd strobe after the press
        merge = 1'b0;
        set_word(0, 10'h100);
        cycle();
        set_word(0, 10'h000);
        fs_cnt = 0; n = 0;
        while (coin_n[0] == 1'b0 && n < 200) begin
            cycle();
            if (m_fs) fs_cnt++;
            n++;
        end
        check("coin_tap_bound", 32'(n < 200), 32'd1);
        check("coin_tap_fs", 32'(fs_cnt), 32'(CF));
        repeat (5) cycle();

        // Coin held for 10 frames
        set_word(0, 10'h100);
        repeat (120) cycle();
        check("coin_held", 32'(coin_n[0]), 32'd0);
        set_word(0, 10'h000);
        repeat (2) cycle();
        check("coin_released", 32'(coin_n[0]), 32'd1);

        // Autofire for 20 frames, then release
        af_en = 2'b01;
        set_word(0, 10'h010);
        repeat (240) cycle();
        set_word(0, 10'h000);
        cycle();
        check("af_release", 32'(joy_n[4]), 32'd1);
        af_en = '0;
        repeat (3) cycle();

        // Pause latch: two taps, tap under soft reset, long hold
        set_word(1, 10'h200); cycle(); set_word(1, 10'h000); cycle();
        check("pause_tap1", 32'(pause), 32'd1);
        set_word(1, 10'h200); cycle(); set_word(1, 10'h000); cycle();
        check("pause_tap2", 32'(pause), 32'd0);
        soft_rst = 1'b1; set_word(1, 10'h200); cycle();
        soft_rst = 1'b0; set_word(1, 10'h000); cycle();
        check("pause_soft_rst", 32'(pause), 32'd0);
        set_word(0, 10'h200);
        repeat (50) cycle();
        set_word(0, 10'h000);
        repeat (2) cycle();
        check("pause_hold", 32'(pause), 32'd1);

        // Separate mode: player 2 start and coin
        set_word(1, 10'h140);
        cycle();
        check("sep_start_n", 32'(start_n), 32'(2'b01));
        check("sep_coin_n", 32'(coin_n), 32'(2'b01));
        check("sep_p1_slice", 32'(joy_n[5:0]), 32'(6'h3F));
        set_word(1, 10'h000);
        repeat (60) cycle();

        // Async reset during a coin stretch and an autofire burst
        af_en = 2'b01;
        set_word(0, 10'h110);
        repeat (20) cycle();
        #3 rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        repeat (2) @(posedge clk_sys);
        #1;
        check_reset_values("rst_held");
        rst_n = 1'b1;
        model_reset();
        cycle();
        check("coin_after_rst", 32'(coin_n[0]), 32'd0);
        repeat (40) cycle();
        joy_in = '0; af_en = '0;
        repeat (5) cycle();

        // Random stimulus
        vs_rand = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            for (int b = 0; b < NP*JW; b++)
                if ($urandom_range(0, 15) == 0) joy_in[b] = ~joy_in[b];
            if ($urandom_range(0, 199) == 0) merge = ~merge;
            if ($urandom_range(0, 99) == 0) af_en = NP'($urandom_range(0, 3));
            soft_rst = ($urandom_range(0, 63) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
